// File: rtl/hazard_ctrl.sv
// Load-use hazard detection and branch flush control for a five-stage pipeline.
// Stalls for LOAD_LAT cycles per load-use hazard and keeps a saturating stall counter.
module hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MEMREAD_ID_EX,
    input  logic [ADDR_W-1:0] ARD_ID_EX,
    input  logic [ADDR_W-1:0] ARS1_IF_ID,
    input  logic [ADDR_W-1:0] ARS2_IF_ID,
    input  logic              USES_RS1_IF_ID,
    input  logic              USES_RS2_IF_ID,
    input  logic              BRANCH_TAKEN_EX,
    input  logic              CNT_CLR,
    output logic              STALL,
    output logic              MUX_SEL,
    output logic              FLUSH_IF_ID,
    output logic              FLUSH_ID_EX,
    output logic              BUSY,
    output logic [CNT_W-1:0]  STALL_CNT
);

    typedef enum logic {
        IDLE,
        LSTALL
    } state_t;

    // The first stall cycle is spent in IDLE, so LSTALL covers the remaining LOAD_LAT-1 cycles.
    localparam logic [3:0]       REM_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [3:0]       rem;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             haz;
    logic             in_lstall;
    logic             stall_raw;

    always_comb begin
        haz = MEMREAD_ID_EX && (ARD_ID_EX != '0) &&
              ((USES_RS1_IF_ID && (ARS1_IF_ID == ARD_ID_EX)) ||
               (USES_RS2_IF_ID && (ARS2_IF_ID == ARD_ID_EX)));
    end

    // A taken branch squashes the dependent instruction, so it always overrides a stall.
    always_comb begin
        in_lstall = (state == LSTALL);
        stall_raw = !BRANCH_TAKEN_EX && (in_lstall || haz);
    end

    always_comb begin
        STALL       = RST_N && stall_raw;
        MUX_SEL     = RST_N && stall_raw;
        FLUSH_IF_ID = RST_N && BRANCH_TAKEN_EX;
        FLUSH_ID_EX = RST_N && BRANCH_TAKEN_EX;
        BUSY        = RST_N && in_lstall;
        STALL_CNT   = stall_cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            rem   <= 4'd0;
        end else if (BRANCH_TAKEN_EX) begin
            state <= IDLE;
            rem   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (haz && (LOAD_LAT > 1)) begin
                        state <= LSTALL;
                        rem   <= REM_INIT;
                    end
                end
                LSTALL: begin
                    if (rem == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rem   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
        end else if (CNT_CLR) begin
            stall_cnt_q <= '0;
        end else if (stall_raw && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

endmodule
